maze_query_arbiter: RTL and testbench

//  Shares the single-port synchronous maze wall lookup (1 bit per tile, 1-cycle read) between
//  the VGA tile renderer and N game-logic requesters (pacman/ghost wall-collision checks).
//  The renderer has fixed priority and fixed latency. Game requesters are served round-robin

---
 rtl/maze_query_arbiter_if.sv | 28 ++
 rtl/maze_query_arbiter.sv | 149 ++++++++++++++
 tb/tb_maze_query_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/maze_query_arbiter_if.sv
// Lookup bus between the maze wall arbiter and its clients: renderer port plus N game requesters.
interface maze_query_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int RW    = 3,
  parameter int CW    = 3
);
  logic                  render_en;
  logic [RW-1:0]         render_row;
  logic [CW-1:0]         render_col;
  logic                  render_valid;
  logic                  render_wall;
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ*RW-1:0]   req_row;
  logic [N_REQ*CW-1:0]   req_col;
  logic [N_REQ-1:0]      req_ready;
  logic [N_REQ-1:0]      rsp_valid;
  logic                  rsp_wall;

  modport master (
    output render_en, render_row, render_col, req_valid, req_row, req_col,
    input  render_valid, render_wall, req_ready, rsp_valid, rsp_wall
  );

  modport slave (
    input  render_en, render_row, render_col, req_valid, req_row, req_col,
    output render_valid, render_wall, req_ready, rsp_valid, rsp_wall
  );
endinterface

// File: rtl/maze_query_arbiter.sv
// Shares the single-port maze wall ROM between a fixed-priority renderer and round-robin
// game requesters; both sources see a fixed two-cycle lookup latency.
module maze_query_arbiter #(
  parameter int MAZE_ROWS    = 8,
  parameter int MAZE_COLS    = 8,
  parameter int RW           = 3,
  parameter int CW           = 3,
  parameter int N_REQ        = 2,
  parameter int STARVE_LIMIT = 800
) (
  input  logic                  clk,
  input  logic                  reset,
  maze_query_arbiter_if.slave   bus,
  output logic                  mem_en,
  output logic [RW-1:0]         mem_row,
  output logic [CW-1:0]         mem_col,
  input  logic                  mem_wall,
  output logic                  starve_err
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WW = $clog2(STARVE_LIMIT + 1);

  function automatic logic is_oor(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return (int'(r) >= MAZE_ROWS) || (int'(c) >= MAZE_COLS);
  endfunction

  function automatic logic [WW-1:0] sat_inc(input logic [WW-1:0] v);
    return (v >= WW'(STARVE_LIMIT)) ? v : v + WW'(1);
  endfunction

  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
  logic             starve_err_q, starve_err_d;

  logic             mem_en_p1_q, mem_en_p1_d;
  logic [RW-1:0]    mem_row_p1_q, mem_row_p1_d;
  logic [CW-1:0]    mem_col_p1_q, mem_col_p1_d;
  logic             vld_p1_q, vld_p1_d;
  logic             rnd_p1_q, rnd_p1_d;
  logic [PW-1:0]    idx_p1_q, idx_p1_d;
  logic             oor_p1_q, oor_p1_d;

  logic             render_valid_p2_q, render_valid_p2_d;
  logic [N_REQ-1:0] rsp_valid_p2_q, rsp_valid_p2_d;
  logic             oor_p2_q, oor_p2_d;

  logic [PW:0]      scan_idx;
  logic [PW-1:0]    grant_idx;
  logic             grant_found;
  logic [N_REQ-1:0] grant_oh;
  logic [RW-1:0]    sel_row;
  logic [CW-1:0]    sel_col;
  logic             issue;
  logic             sel_oor;

  // Stage 0: round-robin search starting at rr_ptr, suppressed while the renderer owns the slot
  always_comb begin
    scan_idx    = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    grant_oh    = '0;
    if (!bus.render_en) begin
      for (int k = 0; k < N_REQ; k++) begin
        scan_idx = {1'b0, rr_ptr_q} + (PW+1)'(k);
        if (scan_idx >= (PW+1)'(N_REQ)) scan_idx = scan_idx - (PW+1)'(N_REQ);
        if (!grant_found && bus.req_valid[scan_idx[PW-1:0]]) begin
          grant_found = 1'b1;
          grant_idx   = scan_idx[PW-1:0];
        end
      end
    end
    if (grant_found) grant_oh[grant_idx] = 1'b1;
  end

  always_comb begin
    sel_row = bus.render_en ? bus.render_row : bus.req_row[int'(grant_idx)*RW +: RW];
    sel_col = bus.render_en ? bus.render_col : bus.req_col[int'(grant_idx)*CW +: CW];
    issue   = bus.render_en | grant_found;
    sel_oor = is_oor(sel_row, sel_col);
  end

  always_comb begin
    mem_en_p1_d       = issue & ~sel_oor;
    mem_row_p1_d      = issue ? sel_row : mem_row_p1_q;
    mem_col_p1_d      = issue ? sel_col : mem_col_p1_q;
    vld_p1_d          = issue;
    rnd_p1_d          = bus.render_en;
    idx_p1_d          = grant_idx;
    oor_p1_d          = sel_oor;

    render_valid_p2_d = vld_p1_q & rnd_p1_q;
    rsp_valid_p2_d    = '0;
    if (vld_p1_q && !rnd_p1_q) rsp_valid_p2_d[idx_p1_q] = 1'b1;
    oor_p2_d          = oor_p1_q;

    rr_ptr_d = rr_ptr_q;
    if (grant_found) rr_ptr_d = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + PW'(1);

    // Waiting means a game request is pending but none moved this cycle
    if (grant_found || !(|bus.req_valid)) wait_cnt_d = '0;
    else                                  wait_cnt_d = sat_inc(wait_cnt_q);
    starve_err_d = starve_err_q | (wait_cnt_d == WW'(STARVE_LIMIT));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q          <= '0;
      wait_cnt_q        <= '0;
      starve_err_q      <= 1'b0;
      mem_en_p1_q       <= 1'b0;
      mem_row_p1_q      <= '0;
      mem_col_p1_q      <= '0;
      vld_p1_q          <= 1'b0;
      rnd_p1_q          <= 1'b0;
      idx_p1_q          <= '0;
      oor_p1_q          <= 1'b0;
      render_valid_p2_q <= 1'b0;
      rsp_valid_p2_q    <= '0;
      oor_p2_q          <= 1'b0;
    end else begin
      rr_ptr_q          <= rr_ptr_d;
      wait_cnt_q        <= wait_cnt_d;
      starve_err_q      <= starve_err_d;
      mem_en_p1_q       <= mem_en_p1_d;
      mem_row_p1_q      <= mem_row_p1_d;
      mem_col_p1_q      <= mem_col_p1_d;
      vld_p1_q          <= vld_p1_d;
      rnd_p1_q          <= rnd_p1_d;
      idx_p1_q          <= idx_p1_d;
      oor_p1_q          <= oor_p1_d;
      render_valid_p2_q <= render_valid_p2_d;
      rsp_valid_p2_q    <= rsp_valid_p2_d;
      oor_p2_q          <= oor_p2_d;
    end
  end

  // Stage 2: ROM data arrives now; out-of-range lookups are forced to read as wall
  assign bus.req_ready    = grant_oh;
  assign bus.render_valid = render_valid_p2_q;
  assign bus.render_wall  = render_valid_p2_q & (oor_p2_q | mem_wall);
  assign bus.rsp_valid    = rsp_valid_p2_q;
  assign bus.rsp_wall     = (|rsp_valid_p2_q) & (oor_p2_q | mem_wall);
  assign mem_en           = mem_en_p1_q;
  assign mem_row          = mem_row_p1_q;
  assign mem_col          = mem_col_p1_q;
  assign starve_err       = starve_err_q;

endmodule

// File: tb/tb_maze_query_arbiter.sv
// Bench for maze_query_arbiter: scenario tasks plus random traffic against a scheduled-event model.
module tb_maze_query_arbiter;
  localparam int N_REQ = 2, RW = 3, CW = 3, MAZE_ROWS = 6, MAZE_COLS = 8, LIMIT = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_en, mem_wall, starve_err;
  logic [RW-1:0] mem_row;
  logic [CW-1:0] mem_col;
  always #5 clk = ~clk;

  maze_query_arbiter_if #(.N_REQ(N_REQ), .RW(RW), .CW(CW)) bus ();

  maze_query_arbiter #(
    .MAZE_ROWS(MAZE_ROWS), .MAZE_COLS(MAZE_COLS), .RW(RW), .CW(CW),
    .N_REQ(N_REQ), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .mem_en(mem_en), .mem_row(mem_row),
    .mem_col(mem_col), .mem_wall(mem_wall), .starve_err(starve_err)
  );

  bit rom [8][8];
  always @(posedge clk) if (mem_en) mem_wall <= rom[mem_row][mem_col];

  int checks = 0, errors = 0;
  int cyc, rr, wcnt, grant;
  bit starve;
  bit pend [N_REQ];
  int          s2_src  [int];
  bit          s2_wall [int];
  bit          s1_men  [int];
  logic [5:0]  s1_addr [int];

  logic [8:0] exp_vec, obs_vec;
  logic [5:0] exp_addr;
  bit         exp_addr_chk;
  assign obs_vec = {bus.req_ready, bus.render_valid, bus.render_wall, bus.rsp_valid,
                    bus.rsp_wall, mem_en, starve_err};

  task automatic model_clear();
    rr = 0; wcnt = 0; starve = 0; cyc = 0;
    for (int i = 0; i < N_REQ; i++) pend[i] = 0;
    s2_src.delete(); s2_wall.delete(); s1_men.delete(); s1_addr.delete();
  endtask

  task automatic model_eval();
    logic [N_REQ-1:0] er, ersp;
    logic erv, erw, erspw, emen;
    grant = -1;
    if (!bus.render_en)
      for (int k = 0; k < N_REQ; k++)
        if (grant < 0 && bus.req_valid[(rr + k) % N_REQ]) grant = (rr + k) % N_REQ;
    er = '0; if (grant >= 0) er[grant] = 1'b1;
    erv = 0; erw = 0; ersp = '0; erspw = 0;
    if (s2_src.exists(cyc)) begin
      if (s2_src[cyc] == N_REQ) begin erv = 1; erw = s2_wall[cyc]; end
      else begin ersp[s2_src[cyc]] = 1'b1; erspw = s2_wall[cyc]; end
    end
    emen = s1_men.exists(cyc) ? s1_men[cyc] : 1'b0;
    exp_addr_chk = emen;
    exp_addr = emen ? s1_addr[cyc] : 6'd0;
    exp_vec = {er, erv, erw, ersp, erspw, emen, starve};
  endtask

  task automatic model_advance();
    int src;
    logic [RW-1:0] r;
    logic [CW-1:0] c;
    bit o;
    src = -1; r = '0; c = '0;
    if (bus.render_en) begin src = N_REQ; r = bus.render_row; c = bus.render_col; end
    else if (grant >= 0) begin
      src = grant; r = bus.req_row[grant*RW +: RW]; c = bus.req_col[grant*CW +: CW];
    end
    if (src >= 0) begin
      o = (int'(r) >= MAZE_ROWS) || (int'(c) >= MAZE_COLS);
      s1_men[cyc+1]  = !o;
      s1_addr[cyc+1] = {r, c};
      s2_src[cyc+2]  = src;
      s2_wall[cyc+2] = o ? 1'b1 : rom[r][c];
    end
    if (grant >= 0 || !(|bus.req_valid)) wcnt = 0;
    else if (wcnt < LIMIT) wcnt++;
    if (wcnt == LIMIT) starve = 1;
    for (int i = 0; i < N_REQ; i++) pend[i] = bus.req_valid[i] && (grant != i);
    if (grant >= 0) rr = (grant + 1) % N_REQ;
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic set_game(input int i, input bit v, input int r, input int c);
    bus.req_valid[i] = v;
    bus.req_row[i*RW +: RW] = RW'(r);
    bus.req_col[i*CW +: CW] = CW'(c);
  endtask

  task automatic idle_inputs();
    bus.render_en = 0; bus.render_row = '0; bus.render_col = '0;
    bus.req_valid = '0; bus.req_row = '0; bus.req_col = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1; @(posedge clk); #1; reset = 0;
    model_clear();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs_vec !== 9'd0) begin errors++; $display("FAIL reset_outputs got=%b want=%b", obs_vec, 9'd0); end
    checks++;
    if ({mem_row, mem_col} !== 6'd0) begin errors++; $display("FAIL reset_addr got=%b want=0", {mem_row, mem_col}); end
    @(posedge clk); #1; reset = 0;
    model_clear();
  endtask

  task automatic test_render_only();
    rom[2][3] = 1;
    for (int k = 0; k < 3; k++) begin
      idle_inputs();
      if (k == 0) begin bus.render_en = 1; bus.render_row = 3'd2; bus.render_col = 3'd3; end
      @(negedge clk); model_eval();
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL render_only k=%0d got=%b want=%b", k, obs_vec, exp_vec); end
      if (k == 1) begin
        checks++;
        if ({mem_en, mem_row, mem_col} !== {1'b1, 3'd2, 3'd3}) begin
          errors++; $display("FAIL render_mem_addr got=%b want=%b", {mem_en, mem_row, mem_col}, {1'b1, 3'd2, 3'd3});
        end
      end
      if (k == 2) begin
        checks++;
        if ({bus.render_valid, bus.render_wall} !== 2'b11) begin
          errors++; $display("FAIL render_result got=%b want=11", {bus.render_valid, bus.render_wall});
        end
      end
      model_advance();
    end
  endtask

  task automatic test_alternate();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      idle_inputs();
      if (k < 8) begin set_game(0, 1, 1, 1); set_game(1, 1, 2, 5); end
      @(negedge clk); model_eval();
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL alternate k=%0d got=%b want=%b", k, obs_vec, exp_vec); end
      if (exp_addr_chk) begin
        checks++;
        if ({mem_row, mem_col} !== exp_addr) begin errors++; $display("FAIL alternate_addr k=%0d got=%b want=%b", k, {mem_row, mem_col}, exp_addr); end
      end
      if (k < 8) begin
        checks++;
        if (bus.req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
          errors++; $display("FAIL alternate_grant k=%0d got=%b want=%b", k, bus.req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
        end
      end
      model_advance();
    end
  endtask

  task automatic test_render_block();
    for (int k = 0; k < 9; k++) begin
      idle_inputs();
      if (k < 5) begin bus.render_en = 1; bus.render_row = 3'(k); bus.render_col = 3'(k + 1); end
      if (k < 7) set_game(1, 1, 4, 6);
      @(negedge clk); model_eval();
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL render_block k=%0d got=%b want=%b", k, obs_vec, exp_vec); end
      if (k <= 5) begin
        checks++;
        if (bus.req_ready !== ((k == 5) ? 2'b10 : 2'b00)) begin
          errors++; $display("FAIL render_block_ready k=%0d got=%b want=%b", k, bus.req_ready, (k == 5) ? 2'b10 : 2'b00);
        end
      end
      if (k == 7) begin
        checks++;
        if (bus.rsp_valid !== 2'b10) begin errors++; $display("FAIL render_block_rsp got=%b want=10", bus.rsp_valid); end
      end
      model_advance();
    end
  endtask

  task automatic test_out_of_range();
    for (int k = 0; k < 3; k++) begin
      idle_inputs();
      if (k == 0) set_game(0, 1, 7, 2);
      @(negedge clk); model_eval();
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL oor k=%0d got=%b want=%b", k, obs_vec, exp_vec); end
      if (k == 1) begin
        checks++;
        if (mem_en !== 1'b0) begin errors++; $display("FAIL oor_mem_en got=%b want=0", mem_en); end
      end
      if (k == 2) begin
        checks++;
        if ({bus.rsp_valid, bus.rsp_wall} !== 3'b011) begin
          errors++; $display("FAIL oor_rsp got=%b want=011", {bus.rsp_valid, bus.rsp_wall});
        end
      end
      model_advance();
    end
  endtask

  task automatic test_starvation();
    do_reset();
    for (int k = 0; k < 16; k++) begin
      idle_inputs();
      if (k < 12) begin bus.render_en = 1; bus.render_row = 3'd1; bus.render_col = 3'd1; end
      if (k < 13) set_game(0, 1, 3, 3);
      @(negedge clk); model_eval();
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL starve k=%0d got=%b want=%b", k, obs_vec, exp_vec); end
      if (k == 9 || k == 10 || k == 15) begin
        checks++;
        if (starve_err !== (k != 9)) begin errors++; $display("FAIL starve_flag k=%0d got=%b want=%b", k, starve_err, k != 9); end
      end
      model_advance();
    end
  endtask

  task automatic test_reset_midop();
    idle_inputs(); bus.render_en = 1; bus.render_row = 3'd1; bus.render_col = 3'd2;
    @(negedge clk); model_eval(); model_advance();
    idle_inputs(); set_game(0, 1, 3, 4);
    @(negedge clk); model_eval(); model_advance();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      idle_inputs(); set_game(0, 1, 0, 1); set_game(1, 1, 5, 5);
      @(negedge clk); model_eval();
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL reset_midop k=%0d got=%b want=%b", k, obs_vec, exp_vec); end
      if (k == 0) begin
        checks++;
        if ({bus.req_ready, bus.render_valid, bus.rsp_valid, starve_err} !== 6'b01_0_00_0) begin
          errors++; $display("FAIL reset_midop_state got=%b want=010000", {bus.req_ready, bus.render_valid, bus.rsp_valid, starve_err});
        end
      end
      model_advance();
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      bus.render_en = ($urandom_range(0, 3) == 0);
      bus.render_row = 3'($urandom_range(0, 7));
      bus.render_col = 3'($urandom_range(0, 7));
      for (int i = 0; i < N_REQ; i++)
        if (!pend[i]) set_game(i, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 7));
      @(negedge clk); model_eval();
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL random k=%0d got=%b want=%b", k, obs_vec, exp_vec); end
      if (exp_addr_chk) begin
        checks++;
        if ({mem_row, mem_col} !== exp_addr) begin errors++; $display("FAIL random_addr k=%0d got=%b want=%b", k, {mem_row, mem_col}, exp_addr); end
      end
      model_advance();
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) rom[i][j] = 1'($urandom_range(0, 1));
    test_reset();
    test_render_only();
    test_alternate();
    test_render_block();
    test_out_of_range();
    test_starvation();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
